// File: rtl/bist_pkg.sv
// Shared definitions for the MBIST data-pattern generator: background mode
// encodings and the maximal-length LFSR tap table for widths 2..32.
package bist_pkg;

    localparam int BIST_MODE_W = 3;

    localparam logic [BIST_MODE_W-1:0] BIST_MODE_SOLID     = 3'd0;
    localparam logic [BIST_MODE_W-1:0] BIST_MODE_CHECKER   = 3'd1;
    localparam logic [BIST_MODE_W-1:0] BIST_MODE_COLSTRIPE = 3'd2;
    localparam logic [BIST_MODE_W-1:0] BIST_MODE_WALK1     = 3'd3;
    localparam logic [BIST_MODE_W-1:0] BIST_MODE_LFSR      = 3'd4;

    // Tap masks for a left-shifting Fibonacci LFSR, feedback into bit0.
    // Bit (t-1) is set for every tap t of a primitive polynomial of degree w.
    function automatic logic [31:0] bist_lfsr_taps(input int w);
        logic [31:0] taps;
        case (w)
            2:       taps = 32'h0000_0003;
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0003;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/bist_pat_dly.sv
// Read-latency delay line for {valid, data}; depth 0 degenerates to a wire.
// All stages clear asynchronously so in-flight reads never survive a reset.
module bist_pat_dly #(
    parameter int pWIDTH = 8,
    parameter int pDEPTH = 1
) (
    input  logic              bist_clk,
    input  logic              bist_rst_n,
    input  logic              in_vld,
    input  logic [pWIDTH-1:0] in_data,
    output logic              out_vld,
    output logic [pWIDTH-1:0] out_data
);

    generate
        if (pDEPTH == 0) begin : g_wire
            assign out_vld  = in_vld;
            assign out_data = in_data;
        end else begin : g_shift
            logic [pDEPTH-1:0] vld_q;
            logic [pWIDTH-1:0] data_q [pDEPTH];

            always_ff @(posedge bist_clk or negedge bist_rst_n) begin
                if (!bist_rst_n) begin
                    vld_q <= '0;
                    for (int i = 0; i < pDEPTH; i++) begin
                        data_q[i] <= '0;
                    end
                end else begin
                    vld_q[0]  <= in_vld;
                    data_q[0] <= in_data;
                    for (int i = 1; i < pDEPTH; i++) begin
                        vld_q[i]  <= vld_q[i-1];
                        data_q[i] <= data_q[i-1];
                    end
                end
            end

            assign out_vld  = vld_q[pDEPTH-1];
            assign out_data = data_q[pDEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/bist_data_gen.sv
// MBIST data-pattern generator: registered write data plus latency-aligned
// expected data. Define BIST_PAT_LFSR_EN to add the LFSR background (mode 4).
module bist_data_gen
    import bist_pkg::*;
#(
    parameter int pDATA_WIDTH = 8,
    parameter int pADDR_WIDTH = 10,
    parameter int pRD_LAT     = 1,
    parameter int pLFSR_SEED  = 1
) (
    input  logic                   bist_clk,
    input  logic                   bist_rst_n,
    input  logic                   pat_start,
    input  logic [BIST_MODE_W-1:0] pat_mode,
    input  logic                   pat_inv,
    input  logic                   pat_adv,
    input  logic [pADDR_WIDTH-1:0] bist_addr,
    input  logic                   rd_en,
    output logic [pDATA_WIDTH-1:0] wr_pat,
    output logic [pDATA_WIDTH-1:0] exp_pat,
    output logic                   exp_vld
);

    localparam logic [pDATA_WIDTH-1:0] COL_MASK  = pDATA_WIDTH'(32'hAAAA_AAAA);
    localparam logic [pDATA_WIDTH-1:0] WALK_INIT = pDATA_WIDTH'(1);

    logic [pDATA_WIDTH-1:0] walk_q;
    logic [pDATA_WIDTH-1:0] bg;
    logic [pDATA_WIDTH-1:0] pat_data;
    logic                   dly_vld;
    logic [pDATA_WIDTH-1:0] dly_data;
    logic                   unused_addr;

    // Only the address LSB matters for the checkerboard.
    assign unused_addr = ^bist_addr;

    // Walking-one register; pat_start has priority over pat_adv.
    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            walk_q <= WALK_INIT;
        end else if (pat_start) begin
            walk_q <= WALK_INIT;
        end else if (pat_adv) begin
            walk_q <= {walk_q[pDATA_WIDTH-2:0], walk_q[pDATA_WIDTH-1]};
        end
    end

`ifdef BIST_PAT_LFSR_EN
    localparam logic [31:0]            SEED_32   = 32'(pLFSR_SEED);
    localparam logic [pDATA_WIDTH-1:0] LFSR_SEED = SEED_32[pDATA_WIDTH-1:0];
    localparam logic [31:0]            TAPS_32   = bist_lfsr_taps(pDATA_WIDTH);
    localparam logic [pDATA_WIDTH-1:0] LFSR_TAPS = TAPS_32[pDATA_WIDTH-1:0];

    logic [pDATA_WIDTH-1:0] lfsr_q;
    logic                   lfsr_fb;

    assign lfsr_fb = ^(lfsr_q & LFSR_TAPS);

    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (pat_start) begin
            lfsr_q <= LFSR_SEED;
        end else if (pat_adv) begin
            lfsr_q <= {lfsr_q[pDATA_WIDTH-2:0], lfsr_fb};
        end
    end
`endif

    // Background selection uses the pre-update walk/LFSR state.
    always_comb begin
        bg = '0;
        case (pat_mode)
            BIST_MODE_CHECKER:   bg = COL_MASK ^ {pDATA_WIDTH{bist_addr[0]}};
            BIST_MODE_COLSTRIPE: bg = COL_MASK;
            BIST_MODE_WALK1:     bg = walk_q;
`ifdef BIST_PAT_LFSR_EN
            BIST_MODE_LFSR:      bg = lfsr_q;
`endif
            default:             bg = '0;
        endcase
    end

    assign pat_data = bg ^ {pDATA_WIDTH{pat_inv}};

    // Stage p0: write data is registered every cycle, independent of rd_en.
    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            wr_pat <= '0;
        end else begin
            wr_pat <= pat_data;
        end
    end

    bist_pat_dly #(
        .pWIDTH (pDATA_WIDTH),
        .pDEPTH (pRD_LAT)
    ) u_dly (
        .bist_clk   (bist_clk),
        .bist_rst_n (bist_rst_n),
        .in_vld     (rd_en),
        .in_data    (pat_data),
        .out_vld    (dly_vld),
        .out_data   (dly_data)
    );

    // Output stage: exp_pat holds its last value between valid reads.
    always_ff @(posedge bist_clk or negedge bist_rst_n) begin
        if (!bist_rst_n) begin
            exp_vld <= 1'b0;
            exp_pat <= '0;
        end else begin
            exp_vld <= dly_vld;
            if (dly_vld) begin
                exp_pat <= dly_data;
            end
        end
    end

endmodule

// File: tb/tb_bist_data_gen.sv
// Directed bench for bist_data_gen: W=8/latency 2 main instance plus a
// W=4/latency 0 instance for the LFSR background and wire-through delay.
module tb_bist_data_gen;

    logic       bist_clk;
    logic       bist_rst_n;
    logic       pat_start;
    logic [2:0] pat_mode;
    logic       pat_inv;
    logic       pat_adv;
    logic [9:0] bist_addr;
    logic       rd_en;

    logic [7:0] wr8, exp8;
    logic       vld8;
    logic [3:0] wr4, exp4;
    logic       vld4;

    int n_chk  = 0;
    int n_fail = 0;

    bist_data_gen #(
        .pDATA_WIDTH (8),
        .pADDR_WIDTH (10),
        .pRD_LAT     (2),
        .pLFSR_SEED  (1)
    ) u_dut8 (
        .bist_clk   (bist_clk),
        .bist_rst_n (bist_rst_n),
        .pat_start  (pat_start),
        .pat_mode   (pat_mode),
        .pat_inv    (pat_inv),
        .pat_adv    (pat_adv),
        .bist_addr  (bist_addr),
        .rd_en      (rd_en),
        .wr_pat     (wr8),
        .exp_pat    (exp8),
        .exp_vld    (vld8)
    );

    bist_data_gen #(
        .pDATA_WIDTH (4),
        .pADDR_WIDTH (10),
        .pRD_LAT     (0),
        .pLFSR_SEED  (1)
    ) u_dut4 (
        .bist_clk   (bist_clk),
        .bist_rst_n (bist_rst_n),
        .pat_start  (pat_start),
        .pat_mode   (pat_mode),
        .pat_inv    (pat_inv),
        .pat_adv    (pat_adv),
        .bist_addr  (bist_addr),
        .rd_en      (rd_en),
        .wr_pat     (wr4),
        .exp_pat    (exp4),
        .exp_vld    (vld4)
    );

    initial bist_clk = 1'b0;
    always #5 bist_clk = ~bist_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge bist_clk);
        #1;
    endtask

    initial begin
        logic [3:0] lfsr_seq [15];
        lfsr_seq = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                     4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8};

        bist_rst_n = 1'b0;
        pat_start  = 1'b0;
        pat_mode   = 3'd0;
        pat_inv    = 1'b1;
        pat_adv    = 1'b0;
        bist_addr  = '0;
        rd_en      = 1'b1;
        step();
        step();
        chk("rst_wr", 32'(wr8), 32'h00);
        chk("rst_exp", 32'(exp8), 32'h00);
        chk("rst_vld", 32'(vld8), 32'h0);
        rd_en = 1'b0;
        bist_rst_n = 1'b1;

        // SOLID, no reads
        pat_inv = 1'b0; step();
        chk("solid_wr0", 32'(wr8), 32'h00);
        pat_inv = 1'b1; step();
        chk("solid_wr1", 32'(wr8), 32'hFF);
        step();
        chk("solid_vld", 32'(vld8), 32'h0);
        chk("solid_exp", 32'(exp8), 32'h00);

        // CHECKER, no reads
        pat_mode = 3'd1; pat_inv = 1'b0;
        bist_addr = 10'd0; step(); chk("chk_wr_a0", 32'(wr8), 32'hAA);
        bist_addr = 10'd1; step(); chk("chk_wr_a1", 32'(wr8), 32'h55);
        bist_addr = 10'd2; step(); chk("chk_wr_a2", 32'(wr8), 32'hAA);

        // CHECKER with reads, expected three edges later
        rd_en = 1'b1;
        bist_addr = 10'd0; step();
        chk("chkrd_wr0", 32'(wr8), 32'hAA);
        chk("chkrd_vld_early0", 32'(vld8), 32'h0);
        bist_addr = 10'd1; step();
        chk("chkrd_wr1", 32'(wr8), 32'h55);
        chk("chkrd_vld_early1", 32'(vld8), 32'h0);
        bist_addr = 10'd2; step();
        chk("chkrd_wr2", 32'(wr8), 32'hAA);
        chk("chkrd_exp0", 32'(exp8), 32'hAA);
        chk("chkrd_vld0", 32'(vld8), 32'h1);
        rd_en = 1'b0; pat_mode = 3'd0; step();
        chk("chkrd_exp1", 32'(exp8), 32'h55);
        chk("chkrd_vld1", 32'(vld8), 32'h1);
        step();
        chk("chkrd_exp2", 32'(exp8), 32'hAA);
        chk("chkrd_vld2", 32'(vld8), 32'h1);
        step();
        chk("chkrd_vld_off", 32'(vld8), 32'h0);
        chk("chkrd_exp_hold", 32'(exp8), 32'hAA);

        // WALK1: reload, nine advances with wrap
        pat_mode = 3'd3; pat_start = 1'b1; step();
        chk("walk_start", 32'(wr8), 32'h01);
        pat_start = 1'b0; pat_adv = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
            chk($sformatf("walk_step%0d", i), 32'(wr8), 32'(8'h01 << (i % 8)));
        end
        pat_adv = 1'b0; step();
        chk("walk_wrap", 32'(wr8), 32'h02);

        // pat_start together with pat_adv: reload, no step
        pat_start = 1'b1; pat_adv = 1'b1; step();
        chk("walk_sa_pre", 32'(wr8), 32'h02);
        pat_start = 1'b0; pat_adv = 1'b0; step();
        chk("walk_sa_load", 32'(wr8), 32'h01);
        step();
        chk("walk_sa_nostep", 32'(wr8), 32'h01);

        // pat_adv still steps the walk register in SOLID mode
        pat_mode = 3'd0; pat_adv = 1'b1; step();
        chk("adv_solid_wr", 32'(wr8), 32'h00);
        pat_mode = 3'd3; pat_adv = 1'b0; step();
        chk("adv_solid_walk", 32'(wr8), 32'h02);

        // COLSTRIPE, back-to-back reads, inversion toggling each cycle
        pat_mode = 3'd2; rd_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            pat_inv = k[0];
            step();
            chk($sformatf("col_wr%0d", k), 32'(wr8), k[0] ? 32'h55 : 32'hAA);
            if (k >= 2) begin
                chk($sformatf("col_exp%0d", k), 32'(exp8), k[0] ? 32'h55 : 32'hAA);
                chk($sformatf("col_vld%0d", k), 32'(vld8), 32'h1);
            end
        end

        // Asynchronous reset in mid-stream
        #2 bist_rst_n = 1'b0;
        #1;
        chk("midrst_vld", 32'(vld8), 32'h0);
        chk("midrst_exp", 32'(exp8), 32'h00);
        chk("midrst_wr", 32'(wr8), 32'h00);
        rd_en = 1'b0; pat_inv = 1'b0;
        step();
        bist_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("postrst_vld%0d", k), 32'(vld8), 32'h0);
        end
        chk("postrst_exp", 32'(exp8), 32'h00);

        // Reserved mode behaves as SOLID
        pat_mode = 3'd6; pat_inv = 1'b0; step();
        chk("mode6_wr0", 32'(wr8), 32'h00);
        pat_inv = 1'b1; rd_en = 1'b1; step();
        chk("mode6_wr1", 32'(wr8), 32'hFF);
        chk("lat0_wr", 32'(wr4), 32'hF);
        chk("lat0_exp", 32'(exp4), 32'hF);
        chk("lat0_vld", 32'(vld4), 32'h1);
        rd_en = 1'b0; pat_inv = 1'b0; step();
        chk("lat0_vld_off", 32'(vld4), 32'h0);
        chk("lat0_exp_hold", 32'(exp4), 32'hF);

`ifdef BIST_PAT_LFSR_EN
        // LFSR W=4 seed 1: full 15-state cycle, then back to seed
        pat_mode = 3'd4; pat_inv = 1'b0;
        pat_start = 1'b1; step();
        chk("lfsr_start", 32'(wr4), 32'h1);
        pat_start = 1'b0; pat_adv = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step();
            chk($sformatf("lfsr_step%0d", i), 32'(wr4), 32'(lfsr_seq[i]));
        end
        pat_adv = 1'b0; step();
        chk("lfsr_wrap", 32'(wr4), 32'h1);
`else
        // Without the LFSR, mode 4 is SOLID
        pat_mode = 3'd4; pat_inv = 1'b0; pat_adv = 1'b1; step();
        chk("mode4_wr8", 32'(wr8), 32'h00);
        chk("mode4_wr4", 32'(wr4), 32'h0);
        pat_adv = 1'b0; step();
        chk("mode4_wr4_again", 32'(wr4), 32'h0);
        if (lfsr_seq[0] != 4'h1) $display("note: seq table unused in this build");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
